pb_debounce_multi: RTL and testbench
====================================

PB_DEBOUNCE_MULTI -- requirements
Module: pb_debounce_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent push-button channels (1..16).
REQ-002 SHALL have parameter STABLE_CNT, default 7500: cycles of stable input needed to accept a change (1.5 ms at 5 MHz).
REQ-003 SHALL have parameter CNT_W, default 13: debounce counter width; STABLE_CNT <= 2^CNT_W - 1 is required.
REQ-004 SHALL have parameter REPEAT_DELAY, default 2500000: cycles from press to first repeat pulse (0.5 s).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 500000: cycles between subsequent repeat pulses (0.1 s).
REQ-006 SHALL have port clk5, input, 1 bit: 5 MHz clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port pb_in, input, N_CH bits: raw asynchronous button levels, 1 = pressed.
REQ-009 SHALL have port pb_level, output, N_CH bits: debounced level per channel.
REQ-010 SHALL have port pb_press, output, N_CH bits: one-cycle pulse on the debounced rising edge.
REQ-011 SHALL have port pb_release, output, N_CH bits: one-cycle pulse on the debounced falling edge.
REQ-012 SHALL have port pb_repeat, output, N_CH bits: one-cycle auto-repeat pulses while held.

Function
REQ-013 SHALL pass each pb_in bit through a 2-flop synchronizer; only the second flop (sync) feeds the channel logic.
REQ-014 SHALL implement one FSM per channel: IDLE (level 0), CHK_HI, HELD (level 1), CHK_LO.
REQ-015 IDLE: sync=1 -> CHK_HI, count=1; otherwise stay, count=0.
REQ-016 CHK_HI: sync=0 -> IDLE, count=0 (bounce restarts qualification); sync=1 with count<STABLE_CNT -> count+1; sync=1 with count==STABLE_CNT -> HELD.
REQ-017 HELD/CHK_LO SHALL mirror REQ-015/016 with sync=0 qualifying a release, returning to IDLE.
REQ-018 Counter SHALL never exceed STABLE_CNT and never wrap.
REQ-019 pb_level SHALL be registered, high exactly while the FSM is in HELD or CHK_LO.
REQ-020 pb_press/pb_release SHALL assert for exactly one cycle, in the first cycle pb_level shows its new value.
REQ-021 Latency: pb_in stable from before edge k changes pb_level at edge k+STABLE_CNT+2.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-023 A pulse shorter than STABLE_CNT+1 synchronized cycles SHALL produce no output change.

Reset
REQ-024 reset SHALL force sync flops 0, all FSMs to IDLE, all counters 0, and pb_level, pb_press, pb_release, pb_repeat to 0 on the next edge.
REQ-025 reset SHALL override all other activity; with pb_in held high through reset deassertion, a full re-qualification SHALL occur and a fresh pb_press SHALL be emitted.
REQ-026 No pb_release SHALL be emitted as a consequence of reset.

Configuration
REQ-027 Macro PB_AUTOREPEAT_EN defined: a per-channel hold counter SHALL clear on entry to HELD, pb_repeat SHALL pulse REPEAT_DELAY cycles after pb_press, then every REPEAT_PERIOD cycles while in HELD.
REQ-028 Repeat SHALL stop immediately on leaving HELD, with no pulse in that cycle; the hold counter SHALL not wrap.
REQ-029 Macro PB_AUTOREPEAT_EN undefined: the pb_repeat port SHALL remain present, be tied to 0, and no hold counters SHALL be synthesised.

Verification (bench: N_CH=4, STABLE_CNT=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-030 Clean press: ch0 high at edge 10 -> pb_level[0]=1 and pb_press[0]=1 for one cycle at edge 20; ch1-3 unchanged.
REQ-031 Bounce: ch1 toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one pb_press[1], 10 edges after the final rise.
REQ-032 Glitch: ch2 high for 7 cycles -> no pb_level, pb_press, or pb_release activity.
REQ-033 Simultaneous: ch0 and ch3 released on the same edge -> pb_release=4'b1001 in one cycle.
REQ-034 Reset mid-hold: ch0 held, reset for 2 cycles -> outputs 0 with no release pulse; fresh pb_press 10 edges after reset drops.
REQ-035 PB_AUTOREPEAT_EN: hold ch0 for 50 cycles past press -> pb_repeat[0] at +20, +25, ..., +50; no repeat after release; all-zero pb_repeat with the macro undefined.

Source files
------------

// File: rtl/pb_debounce_multi.sv
// Multi-channel push-button debouncer: level, press/release pulses and, with PB_AUTOREPEAT_EN
// defined, auto-repeat pulses while held. pb_level lags a stable pb_in by STABLE_CNT+2 cycles.
module pb_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CNT    = 7500,
  parameter int CNT_W         = 13,
  parameter int REPEAT_DELAY  = 2500000,
  parameter int REPEAT_PERIOD = 500000
) (
  input  logic            clk5,
  input  logic            reset,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_press,
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] pb_repeat
);

  typedef enum logic [1:0] {IDLE, CHK_HI, HELD, CHK_LO} state_t;

  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("pb_debounce_multi: N_CH must be 1..16");
  end
  if (STABLE_CNT < 1 || STABLE_CNT > (2**CNT_W) - 1) begin : g_bad_cnt
    $error("pb_debounce_multi: STABLE_CNT must fit in CNT_W bits");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
    $error("pb_debounce_multi: repeat timings must be at least 1");
  end

  logic [N_CH-1:0] meta_q;
  logic [N_CH-1:0] sync_q;

  always_ff @(posedge clk5) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= pb_in;
      sync_q <= meta_q;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, press_q, release_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (sync_q[g]) begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        CHK_HI: begin
          // Any bounce throws away the partial qualification.
          if (!sync_q[g]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q < STABLE_V) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (!sync_q[g]) begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        CHK_LO: begin
          if (sync_q[g]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q < STABLE_V) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk5) begin
      if (reset) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= (state_d == HELD) || (state_d == CHK_LO);
        press_q   <= (state_q == CHK_HI) && (state_d == HELD);
        release_q <= (state_q == CHK_LO) && (state_d == IDLE);
      end
    end

    assign pb_level[g]   = level_q;
    assign pb_press[g]   = press_q;
    assign pb_release[g] = release_q;

`ifdef PB_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_q, hold_d, thr;
    logic              first_q, first_d, rpt_q, rpt_d;

    // The counter restarts after every pulse, so it only ever climbs to the current threshold.
    assign thr = first_q ? HOLD_W'(REPEAT_DELAY) : HOLD_W'(REPEAT_PERIOD);

    always_comb begin
      hold_d  = hold_q;
      first_d = first_q;
      rpt_d   = 1'b0;
      if (state_d == HELD && state_q != HELD) begin
        hold_d  = '0;
        first_d = 1'b1;
      end else if (state_q == HELD && state_d == HELD) begin
        if (hold_q + HOLD_W'(1) == thr) begin
          rpt_d   = 1'b1;
          hold_d  = '0;
          first_d = 1'b0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    end

    always_ff @(posedge clk5) begin
      if (reset) begin
        hold_q  <= '0;
        first_q <= 1'b1;
        rpt_q   <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        first_q <= first_d;
        rpt_q   <= rpt_d;
      end
    end

    assign pb_repeat[g] = rpt_q;
`else
    assign pb_repeat[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Bench for pb_debounce_multi: table-driven phases plus directed corner sequences, with a
// per-edge scoreboard fed by a stable-window model of the debouncer.
module tb_pb_debounce_multi;
  localparam int N_CH = 4;
  localparam int ST   = 8;
  localparam int CW   = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int MAXE = 4096;
`ifdef PB_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic       clk5 = 1'b0;
  logic       reset;
  logic [3:0] pb_in;
  logic [3:0] pb_level, pb_press, pb_release, pb_repeat;

  pb_debounce_multi #(
    .N_CH(N_CH), .STABLE_CNT(ST), .CNT_W(CW), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk5(clk5), .reset(reset), .pb_in(pb_in), .pb_level(pb_level),
    .pb_press(pb_press), .pb_release(pb_release), .pb_repeat(pb_repeat)
  );

  always #5 clk5 = ~clk5;

  int edge_cnt = 0;
  always @(posedge clk5) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         edge_n;
    int         tag;
    logic [3:0] lvl, prs, rel, rpt;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] pin;
    logic       rst;
    int         cycles;
    logic [3:0] exp_lvl;
  } vec_t;
  vec_t tbl[6];
  int   row_start[6];

  int vectors = 0;
  int miscompares = 0;
  int cur_tag = 0;

  logic       rst_h[MAXE];
  logic [3:0] eff_h[MAXE], s_h[MAXE], lvl_h[MAXE], inh_h[MAXE];
  int         start_e[4];

  int prs_cnt[4], rel_cnt[4], last_prs[4];
  bit rel1001_seen = 1'b0;
  int rpt0_edges[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Level follows a channel only once ST+1 consecutive synchronized samples agree.
  task automatic step(input logic [3:0] pin, input logic rst);
    int n;
    exp_t e;
    logic [3:0] s;
    bit stable;
    n = edge_cnt + 1;
    if (n >= MAXE) begin
      $display("FAIL edge_budget: got %0d, want < %0d", n, MAXE);
      $fatal(1);
    end
    pb_in = pin;
    reset = rst;
    rst_h[n] = rst;
    eff_h[n] = rst ? 4'b0 : pin;
    s = (rst || n < 3 || rst_h[n-1]) ? 4'b0 : eff_h[n-2];
    s_h[n] = s;
    e.edge_n = n; e.tag = cur_tag;
    e.prs = '0; e.rel = '0; e.rpt = '0;
    if (rst) begin
      lvl_h[n] = '0;
      inh_h[n] = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        stable = (n > ST);
        for (int j = n - ST; j <= n && stable; j++)
          if (s_h[j][c] != s[c]) stable = 1'b0;
        lvl_h[n][c] = stable ? s[c] : lvl_h[n-1][c];
        e.prs[c] = lvl_h[n][c] & ~lvl_h[n-1][c];
        e.rel[c] = ~lvl_h[n][c] & lvl_h[n-1][c];
        inh_h[n][c] = lvl_h[n][c] & s[c];
        if (inh_h[n][c] && !inh_h[n-1][c]) start_e[c] = n;
        if (RPT_ON && inh_h[n][c] && inh_h[n-1][c] && (n - start_e[c]) >= RD &&
            ((n - start_e[c] - RD) % RP) == 0)
          e.rpt[c] = 1'b1;
      end
    end
    e.lvl = lvl_h[n];
    sb.push_back(e);
    @(posedge clk5);
    #2;
  endtask

  exp_t me;
  always @(negedge clk5) begin
    while (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
      me = sb.pop_front();
      vectors++;
      if ({pb_level, pb_press, pb_release, pb_repeat} !== {me.lvl, me.prs, me.rel, me.rpt}) begin
        miscompares++;
        $display("FAIL edge_vec edge=%0d tag=%0d: got lvl=%b prs=%b rel=%b rpt=%b, want lvl=%b prs=%b rel=%b rpt=%b",
                 me.edge_n, me.tag, pb_level, pb_press, pb_release, pb_repeat,
                 me.lvl, me.prs, me.rel, me.rpt);
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (pb_press[c] === 1'b1) begin
        prs_cnt[c]++;
        last_prs[c] = edge_cnt;
      end
      if (pb_release[c] === 1'b1) rel_cnt[c]++;
    end
    if (pb_release === 4'b1001) rel1001_seen = 1'b1;
    if (pb_repeat[0] === 1'b1) rpt0_edges.push_back(edge_cnt);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rise_e, rdrop, rel0_base, rpt_base, n_rpt, act_first, act_last;
    for (int i = 0; i < MAXE; i++) begin
      rst_h[i] = 1'b0; eff_h[i] = '0; s_h[i] = '0; lvl_h[i] = '0; inh_h[i] = '0;
    end
    for (int c = 0; c < 4; c++) begin
      start_e[c] = 0; prs_cnt[c] = 0; rel_cnt[c] = 0; last_prs[c] = -1;
    end
    reset = 1'b1;
    pb_in = '0;

    tbl[0] = '{4'b0000, 1'b1,  3, 4'b0000};  // reset
    tbl[1] = '{4'b0000, 1'b0,  4, 4'b0000};  // idle
    tbl[2] = '{4'b0001, 1'b0, 14, 4'b0001};  // clean press ch0
    tbl[3] = '{4'b0101, 1'b0,  7, 4'b0001};  // 7-cycle glitch on ch2
    tbl[4] = '{4'b1001, 1'b0, 14, 4'b1001};  // press ch3
    tbl[5] = '{4'b0000, 1'b0, 14, 4'b0000};  // ch0+ch3 released together

    for (int i = 0; i < 6; i++) begin
      cur_tag = i;
      row_start[i] = edge_cnt + 1;
      for (int k = 0; k < tbl[i].cycles; k++) step(tbl[i].pin, tbl[i].rst);
      chk("row_level", int'(pb_level), int'(tbl[i].exp_lvl));
    end
    chk("clean_press_edge", last_prs[0], row_start[2] + 10);
    chk("clean_press_count", prs_cnt[0], 1);
    chk("other_ch_quiet", prs_cnt[1], 0);
    chk("glitch_press", prs_cnt[2], 0);
    chk("glitch_release", rel_cnt[2], 0);
    chk("simul_release", int'(rel1001_seen), 1);

    // Bounce on ch1: toggles every 3 cycles for 30 cycles, then holds high.
    cur_tag = 10;
    for (int seg = 0; seg < 10; seg++)
      for (int k = 0; k < 3; k++) step((seg % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
    rise_e = edge_cnt + 1;
    for (int k = 0; k < 14; k++) step(4'b0010, 1'b0);
    chk("bounce_press_count", prs_cnt[1], 1);
    chk("bounce_press_edge", last_prs[1], rise_e + 10);

    // Reset during a hold, then re-qualification and auto-repeat.
    cur_tag = 20;
    for (int k = 0; k < 14; k++) step(4'b0011, 1'b0);
    rel0_base = rel_cnt[0];
    rpt_base = rpt0_edges.size();
    cur_tag = 21;
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
    chk("reset_level", int'(pb_level), 0);
    cur_tag = 22;
    rdrop = edge_cnt + 1;
    for (int k = 0; k < 61; k++) step(4'b0011, 1'b0);
    chk("reset_no_release", rel_cnt[0], rel0_base);
    chk("reset_repress_edge", last_prs[0], rdrop + 10);
    cur_tag = 23;
    for (int k = 0; k < 20; k++) step(4'b0000, 1'b0);
    n_rpt = rpt0_edges.size() - rpt_base;
    act_first = (n_rpt > 0) ? rpt0_edges[rpt_base] : -1;
    act_last  = (n_rpt > 0) ? rpt0_edges[rpt0_edges.size() - 1] : -1;
    chk("repeat_count", n_rpt, RPT_ON ? 7 : 0);
    chk("repeat_first", act_first, RPT_ON ? rdrop + 30 : -1);
    chk("repeat_last", act_last, RPT_ON ? rdrop + 60 : -1);
    chk("release_after_hold", rel_cnt[0], rel0_base + 1);

    @(negedge clk5);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
